// File: rtl/blob_pattern_source.sv
`default_nettype none
// ============================================================================
// Module : blob_pattern_source
// Brief  : Raster pixel-stream generator painting a solid colour square blob
//          on a dim grey background, static, loaded or bouncing, with its
//          true centre published alongside the stream.
// Rev    : 1.0  initial release
// ============================================================================
module blob_pattern_source #(
  parameter int H_ACTIVE  = 1024,
  parameter int V_ACTIVE  = 768,
  parameter int H_TOTAL   = 1344,
  parameter int V_TOTAL   = 806,
  parameter int BLOB_SIZE = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_en,
  input  logic [1:0]  color_sel,
  input  logic        bounce,
  input  logic        load,
  input  logic [9:0]  set_x,
  input  logic [9:0]  set_y,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic [17:0] pixel,
  output logic        active,
  output logic        frame_start,
  output logic [9:0]  center_x,
  output logic [9:0]  center_y
);

  localparam logic [10:0] c_hActive  = 11'(H_ACTIVE);
  localparam logic [10:0] c_hLast    = 11'(H_TOTAL - 1);
  localparam logic [9:0]  c_vActive  = 10'(V_ACTIVE);
  localparam logic [9:0]  c_vLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  c_xMax     = 10'(H_ACTIVE - BLOB_SIZE);
  localparam logic [9:0]  c_yMax     = 10'(V_ACTIVE - BLOB_SIZE);
  localparam logic [9:0]  c_half     = 10'(BLOB_SIZE / 2);
  localparam logic [10:0] c_size     = 11'(BLOB_SIZE);
  localparam logic [9:0]  c_blobX0   = 10'(H_ACTIVE / 2 - BLOB_SIZE / 2);
  localparam logic [9:0]  c_blobY0   = 10'(V_ACTIVE / 2 - BLOB_SIZE / 2);
  localparam logic [9:0]  c_centerX0 = 10'(H_ACTIVE / 2);
  localparam logic [9:0]  c_centerY0 = 10'(V_ACTIVE / 2);
  localparam logic [17:0] c_grey     = 18'h08208;

  logic [10:0] r_hCnt;
  logic [9:0]  r_vCnt;
  logic [9:0]  r_blobX;
  logic [9:0]  r_blobY;
  logic        r_velXNeg;
  logic        r_velYNeg;
  logic        r_loadPend;
  logic [9:0]  r_loadX;
  logic [9:0]  r_loadY;

  logic        w_lineEnd;
  logic        w_frameEnd;
  logic        w_active;
  logic        w_inBlob;
  logic [17:0] w_pixel;
  logic [9:0]  w_setXClamp;
  logic [9:0]  w_setYClamp;
  logic [9:0]  w_stepX;
  logic [9:0]  w_stepY;
  logic        w_nextVelXNeg;
  logic        w_nextVelYNeg;

  assign w_lineEnd   = (r_hCnt == c_hLast);
  assign w_frameEnd  = pixel_en && w_lineEnd && (r_vCnt == c_vLast);
  assign w_active    = (r_hCnt < c_hActive) && (r_vCnt < c_vActive);
  assign w_inBlob    = ({1'b0, r_blobX} <= r_hCnt) &&
                       (r_hCnt < ({1'b0, r_blobX} + c_size)) &&
                       ({1'b0, r_blobY} <= {1'b0, r_vCnt}) &&
                       ({1'b0, r_vCnt} < ({1'b0, r_blobY} + c_size));
  assign w_setXClamp = (set_x > c_xMax) ? c_xMax : set_x;
  assign w_setYClamp = (set_y > c_yMax) ? c_yMax : set_y;

  always_comb begin
    w_pixel = 18'h0;
    if (w_active) begin
      if (w_inBlob) begin
        case (color_sel)
          2'd0:    w_pixel = 18'h3F000;
          2'd1:    w_pixel = 18'h00FC0;
          2'd2:    w_pixel = 18'h0003F;
          default: w_pixel = 18'h3FFFF;
        endcase
      end else begin
        w_pixel = c_grey;
      end
    end
  end

  // A step that would leave the legal range reflects: velocity flips and the
  // blob moves one pixel the other way in the same frame.
  always_comb begin
    w_nextVelXNeg = r_velXNeg;
    w_stepX       = r_blobX;
    if (!r_velXNeg) begin
      if (r_blobX >= c_xMax) begin
        w_nextVelXNeg = 1'b1;
        w_stepX       = r_blobX - 10'd1;
      end else begin
        w_stepX       = r_blobX + 10'd1;
      end
    end else begin
      if (r_blobX == 10'd0) begin
        w_nextVelXNeg = 1'b0;
        w_stepX       = r_blobX + 10'd1;
      end else begin
        w_stepX       = r_blobX - 10'd1;
      end
    end

    w_nextVelYNeg = r_velYNeg;
    w_stepY       = r_blobY;
    if (!r_velYNeg) begin
      if (r_blobY >= c_yMax) begin
        w_nextVelYNeg = 1'b1;
        w_stepY       = r_blobY - 10'd1;
      end else begin
        w_stepY       = r_blobY + 10'd1;
      end
    end else begin
      if (r_blobY == 10'd0) begin
        w_nextVelYNeg = 1'b0;
        w_stepY       = r_blobY + 10'd1;
      end else begin
        w_stepY       = r_blobY - 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hCnt      <= 11'd0;
      r_vCnt      <= 10'd0;
      x           <= 11'd0;
      y           <= 10'd0;
      pixel       <= 18'h0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else if (pixel_en) begin
      x           <= r_hCnt;
      y           <= r_vCnt;
      pixel       <= w_pixel;
      active      <= w_active;
      frame_start <= (r_hCnt == 11'd0) && (r_vCnt == 10'd0);
      if (w_lineEnd) begin
        r_hCnt <= 11'd0;
        r_vCnt <= (r_vCnt == c_vLast) ? 10'd0 : r_vCnt + 10'd1;
      end else begin
        r_hCnt <= r_hCnt + 11'd1;
      end
    end
  end

  // Blob state only moves on the last pixel of a frame so no frame is torn;
  // a load landing on that same pixel stays pending for the following frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blobX    <= c_blobX0;
      r_blobY    <= c_blobY0;
      r_velXNeg  <= 1'b0;
      r_velYNeg  <= 1'b0;
      center_x   <= c_centerX0;
      center_y   <= c_centerY0;
      r_loadPend <= 1'b0;
      r_loadX    <= 10'd0;
      r_loadY    <= 10'd0;
    end else begin
      if (w_frameEnd) begin
        if (r_loadPend) begin
          r_blobX   <= r_loadX;
          r_blobY   <= r_loadY;
          r_velXNeg <= 1'b0;
          r_velYNeg <= 1'b0;
          center_x  <= r_loadX + c_half;
          center_y  <= r_loadY + c_half;
        end else if (bounce) begin
          r_blobX   <= w_stepX;
          r_blobY   <= w_stepY;
          r_velXNeg <= w_nextVelXNeg;
          r_velYNeg <= w_nextVelYNeg;
          center_x  <= w_stepX + c_half;
          center_y  <= w_stepY + c_half;
        end
      end
      if (load) begin
        r_loadPend <= 1'b1;
        r_loadX    <= w_setXClamp;
        r_loadY    <= w_setYClamp;
      end else if (w_frameEnd) begin
        r_loadPend <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blob_pattern_source.sv
`default_nettype none
// ============================================================================
// Module : tb_blob_pattern_source
// Brief  : Self-checking bench for blob_pattern_source on a reduced raster,
//          compared against a frame-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_blob_pattern_source;

  localparam int HA = 40;
  localparam int VA = 30;
  localparam int HT = 48;
  localparam int VT = 34;
  localparam int BS = 8;
  localparam int N  = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pixel_en = 1'b0;
  logic [1:0]  color_sel = 2'd0;
  logic        bounce = 1'b0;
  logic        load = 1'b0;
  logic [9:0]  set_x = 10'd0;
  logic [9:0]  set_y = 10'd0;
  logic [10:0] x;
  logic [9:0]  y;
  logic [17:0] pixel;
  logic        active;
  logic        frame_start;
  logic [9:0]  center_x;
  logic [9:0]  center_y;

  int n_cmp  = 0;
  int n_fail = 0;

  blob_pattern_source #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_TOTAL  (HT),
    .V_TOTAL  (VT),
    .BLOB_SIZE(BS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_en   (pixel_en),
    .color_sel  (color_sel),
    .bounce     (bounce),
    .load       (load),
    .set_x      (set_x),
    .set_y      (set_y),
    .x          (x),
    .y          (y),
    .pixel      (pixel),
    .active     (active),
    .frame_start(frame_start),
    .center_x   (center_x),
    .center_y   (center_y)
  );

  always #5 clk = ~clk;

  wire [60:0] got_vec = {x, y, pixel, active, frame_start, center_x, center_y};

  // Reference model: linear raster position plus frame-level blob state.
  int m_pos, m_bx, m_by, m_vx, m_vy, m_lx, m_ly;
  bit m_pend;
  logic [10:0] e_x;
  logic [9:0]  e_y;
  logic [17:0] e_pix;
  logic        e_act, e_fs;

  function automatic logic [17:0] ref_pixel(int px, int py, logic [1:0] col);
    if (px >= HA || py >= VA) return 18'h0;
    if (px >= m_bx && px < m_bx + BS && py >= m_by && py < m_by + BS) begin
      case (col)
        2'd0:    return 18'h3F000;
        2'd1:    return 18'h00FC0;
        2'd2:    return 18'h0003F;
        default: return 18'h3FFFF;
      endcase
    end
    return 18'h08208;
  endfunction

  function automatic logic [60:0] exp_vec();
    logic [9:0] cx, cy;
    cx = 10'(m_bx + BS / 2);
    cy = 10'(m_by + BS / 2);
    return {e_x, e_y, e_pix, e_act, e_fs, cx, cy};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_bx = HA / 2 - BS / 2; m_by = VA / 2 - BS / 2;
    m_vx = 1; m_vy = 1; m_pend = 0; m_lx = 0; m_ly = 0;
    e_x = '0; e_y = '0; e_pix = '0; e_act = 1'b0; e_fs = 1'b0;
  endtask

  task automatic model_step(bit pe, bit ld, int sx, int sy, logic [1:0] col, bit bnc);
    if (pe) begin
      int px, py;
      px = m_pos % HT;
      py = m_pos / HT;
      e_x = 11'(px); e_y = 10'(py);
      e_act = (px < HA) && (py < VA);
      e_fs = (m_pos == 0);
      e_pix = ref_pixel(px, py, col);
      if (m_pos == N - 1) begin
        if (m_pend) begin
          m_bx = m_lx; m_by = m_ly; m_vx = 1; m_vy = 1; m_pend = 0;
        end else if (bnc) begin
          if (m_bx + m_vx < 0 || m_bx + m_vx > HA - BS) m_vx = -m_vx;
          if (m_by + m_vy < 0 || m_by + m_vy > VA - BS) m_vy = -m_vy;
          m_bx += m_vx; m_by += m_vy;
        end
      end
      m_pos = (m_pos + 1) % N;
    end
    if (ld) begin
      m_pend = 1;
      m_lx = (sx > HA - BS) ? HA - BS : sx;
      m_ly = (sy > VA - BS) ? VA - BS : sy;
    end
  endtask

  task automatic tick(bit pe, bit ld, logic [9:0] sx, logic [9:0] sy, logic [1:0] col, bit bnc);
    pixel_en = pe; load = ld; set_x = sx; set_y = sy; color_sel = col; bounce = bnc;
    @(posedge clk);
    #1;
    model_step(pe, ld, int'(sx), int'(sy), col, bnc);
    pixel_en = 1'b0; load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; pixel_en = 1'b0; load = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #12;
    n_cmp++;
    if ({x, y, pixel, active, frame_start} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {x, y, pixel, active, frame_start});
    end
    n_cmp++;
    if (center_x !== 10'd20) begin
      n_fail++; $display("FAIL reset_center_x: got %0d want 20", center_x);
    end
    n_cmp++;
    if (center_y !== 10'd15) begin
      n_fail++; $display("FAIL reset_center_y: got %0d want 15", center_y);
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_static_frame();
    int blob_cnt, act_cnt, grey_cnt, blank_bad, fs0, fs1;
    blob_cnt = 0; act_cnt = 0; grey_cnt = 0; blank_bad = 0; fs0 = -1; fs1 = -1;
    do_reset();
    for (int i = 0; i <= N; i++) begin
      tick(1'b1, 1'b0, 10'd0, 10'd0, 2'd0, 1'b0);
      n_cmp++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL static_pixel cyc %0d: got %h want %h", i, got_vec, exp_vec());
      end
      if (frame_start === 1'b1) begin
        if (fs0 < 0) fs0 = i; else if (fs1 < 0) fs1 = i;
      end
      if (i < N) begin
        if (pixel === 18'h3F000) blob_cnt++;
        if (pixel === 18'h08208) grey_cnt++;
        if (active === 1'b1) act_cnt++;
        if (active === 1'b0 && pixel !== 18'h0) blank_bad++;
      end
    end
    n_cmp++;
    if (blob_cnt != BS * BS) begin
      n_fail++; $display("FAIL static_blob_count: got %0d want %0d", blob_cnt, BS * BS);
    end
    n_cmp++;
    if (act_cnt != HA * VA) begin
      n_fail++; $display("FAIL static_active_count: got %0d want %0d", act_cnt, HA * VA);
    end
    n_cmp++;
    if (grey_cnt != HA * VA - BS * BS) begin
      n_fail++; $display("FAIL static_grey_count: got %0d want %0d", grey_cnt, HA * VA - BS * BS);
    end
    n_cmp++;
    if (blank_bad != 0) begin
      n_fail++; $display("FAIL static_blank_nonzero: got %0d want 0", blank_bad);
    end
    n_cmp++;
    if (fs0 != 0 || fs1 - fs0 != N) begin
      n_fail++; $display("FAIL frame_period: got first %0d period %0d want 0 / %0d", fs0, fs1 - fs0, N);
    end
    n_cmp++;
    if ({center_x, center_y} !== {10'd20, 10'd15}) begin
      n_fail++; $display("FAIL static_center: got (%0d,%0d) want (20,15)", center_x, center_y);
    end
  endtask

  task automatic test_color_change();
    for (int i = 0; i < N; i++) begin
      tick(1'b1, 1'b0, 10'd0, 10'd0, 2'($urandom_range(0, 3)), 1'b0);
      n_cmp++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL color_pixel cyc %0d: got %h want %h", i, got_vec, exp_vec());
      end
    end
  endtask

  task automatic test_load_midframe();
    int in_cnt, out_cnt;
    in_cnt = 0; out_cnt = 0;
    for (int i = 0; i < N / 2; i++) begin
      tick(1'b1, (i == N / 4), 10'd3, 10'd3, 2'd1, 1'b0);
      n_cmp++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL load_mid_pixel cyc %0d: got %h want %h", i, got_vec, exp_vec());
      end
    end
    tick(1'b1, 1'b1, 10'd10, 10'd5, 2'd1, 1'b0);
    do begin
      tick(1'b1, 1'b0, 10'd0, 10'd0, 2'd1, 1'b0);
      n_cmp++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL load_cur_frame: got %h want %h", got_vec, exp_vec());
      end
    end while (m_pos != 0);
    n_cmp++;
    if ({center_x, center_y} !== {10'd14, 10'd9}) begin
      n_fail++; $display("FAIL load_center: got (%0d,%0d) want (14,9)", center_x, center_y);
    end
    do begin
      tick(1'b1, 1'b0, 10'd0, 10'd0, 2'd1, 1'b0);
      if (pixel === 18'h00FC0) begin
        if (x >= 10 && x <= 17 && y >= 5 && y <= 12) in_cnt++; else out_cnt++;
      end
    end while (m_pos != 0);
    n_cmp++;
    if (in_cnt != BS * BS || out_cnt != 0) begin
      n_fail++; $display("FAIL load_next_frame_blob: got in=%0d out=%0d want %0d/0", in_cnt, out_cnt, BS * BS);
    end
  endtask

  task automatic test_load_clamp();
    tick(1'b1, 1'b1, 10'd1023, 10'd1000, 2'd3, 1'b0);
    do begin
      tick(1'b1, 1'b0, 10'd0, 10'd0, 2'd3, 1'b0);
      n_cmp++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL clamp_pixel: got %h want %h", got_vec, exp_vec());
      end
    end while (m_pos != 0);
    n_cmp++;
    if ({center_x, center_y} !== {10'd36, 10'd26}) begin
      n_fail++; $display("FAIL clamp_center: got (%0d,%0d) want (36,26)", center_x, center_y);
    end
  endtask

  task automatic test_bounce();
    logic [9:0] want_cx [3];
    logic [9:0] want_cy [3];
    want_cx = '{10'd36, 10'd35, 10'd34};
    want_cy = '{10'd8, 10'd9, 10'd10};
    tick(1'b1, 1'b1, 10'd32, 10'd4, 2'd2, 1'b1);
    for (int f = 0; f < 3; f++) begin
      do begin
        tick(1'b1, 1'b0, 10'd0, 10'd0, 2'd2, 1'b1);
        n_cmp++;
        if (got_vec !== exp_vec()) begin
          n_fail++; $display("FAIL bounce_pixel f%0d: got %h want %h", f, got_vec, exp_vec());
        end
      end while (m_pos != 0);
      n_cmp++;
      if ({center_x, center_y} !== {want_cx[f], want_cy[f]}) begin
        n_fail++;
        $display("FAIL bounce_center f%0d: got (%0d,%0d) want (%0d,%0d)", f, center_x, center_y, want_cx[f], want_cy[f]);
      end
    end
  endtask

  task automatic test_sparse_enable();
    logic [60:0] prev;
    int rise0, rise1;
    bit prev_fs;
    rise0 = -1; rise1 = -1;
    do_reset();
    prev = got_vec; prev_fs = 1'b0;
    for (int i = 0; i <= 3 * N; i++) begin
      tick((i % 3) == 0, 1'b0, 10'd0, 10'd0, 2'd0, 1'b1);
      n_cmp++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL sparse_pixel cyc %0d: got %h want %h", i, got_vec, exp_vec());
      end
      if ((i % 3) != 0) begin
        n_cmp++;
        if (got_vec !== prev) begin
          n_fail++; $display("FAIL sparse_hold cyc %0d: got %h want %h", i, got_vec, prev);
        end
      end
      if (frame_start === 1'b1 && !prev_fs) begin
        if (rise0 < 0) rise0 = i; else if (rise1 < 0) rise1 = i;
      end
      prev_fs = (frame_start === 1'b1);
      prev = got_vec;
    end
    n_cmp++;
    if (rise0 != 0 || rise1 - rise0 != 3 * N) begin
      n_fail++; $display("FAIL sparse_period: got first %0d period %0d want 0 / %0d", rise0, rise1 - rise0, 3 * N);
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < N / 3; i++) tick(1'b1, (i == 100), 10'd2, 10'd2, 2'd0, 1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({x, y, pixel} !== 39'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got x=%0d y=%0d pix=%h want 0", x, y, pixel);
    end
    n_cmp++;
    if ({center_x, center_y} !== {10'd20, 10'd15}) begin
      n_fail++; $display("FAIL midreset_center: got (%0d,%0d) want (20,15)", center_x, center_y);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i <= N; i++) begin
      tick(1'b1, 1'b0, 10'd0, 10'd0, 2'd0, 1'b0);
      n_cmp++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL midreset_frame cyc %0d: got %h want %h", i, got_vec, exp_vec());
      end
    end
    n_cmp++;
    if ({center_x, center_y} !== {10'd20, 10'd15}) begin
      n_fail++; $display("FAIL midreset_pend_lost: got (%0d,%0d) want (20,15)", center_x, center_y);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 5000; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
           10'($urandom), 10'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      n_cmp++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h want %h", i, got_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_static_frame();
    test_color_change();
    test_load_midframe();
    test_load_clamp();
    test_bounce();
    test_sparse_enable();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
